// File: rtl/load_store_unit.sv
// Data-bus initiator: computes the effective address, checks width and alignment,
// runs one bounded bus access and returns a single-cycle response.
module load_store_unit #(
    parameter int   WAIT_CYCLES    = 0,
    parameter logic ZERO_IDLE_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [1:0]  resp_cause,
    output logic        bus_rw,
    output logic [1:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write,
    input  logic [31:0] bus_read,
    input  logic        bus_exception
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

    function automatic logic [31:0] mask_len(input logic [31:0] d, input logic [1:0] len);
        case (len)
            2'd0:    return {24'h0, d[7:0]};
            2'd1:    return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] len,
                                                input logic uns);
        case (len)
            2'd0:    return uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'd1:    return uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        unsigned_q, unsigned_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_exc_q, resp_exc_d;
    logic [1:0]  resp_cause_q, resp_cause_d;
    logic        bus_rw_q, bus_rw_d;
    logic [1:0]  bus_len_q, bus_len_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_write_q, bus_write_d;

    logic [31:0] ea;
    logic [1:0]  req_len;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        ea         = req_base + {{20{req_offset[11]}}, req_offset};
        req_len    = req_funct3[1:0];
        illegal    = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110)
                     || (req_store && req_funct3[2]);
        misaligned = ((req_len == 2'd1) && ea[0]) || ((req_len == 2'd2) && (ea[1:0] != 2'b00));

        state_d      = state_q;
        wait_d       = wait_q;
        unsigned_d   = unsigned_q;
        resp_valid_d = 1'b0;
        resp_exc_d   = 1'b0;
        resp_cause_d = 2'd0;
        resp_rdata_d = resp_rdata_q;
        bus_rw_d     = bus_rw_q;
        bus_len_d    = bus_len_q;
        bus_addr_d   = bus_addr_q;
        bus_write_d  = bus_write_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Faults detected here respond without touching the bus.
                    if (illegal || misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                        resp_cause_d = illegal ? 2'd3 : 2'd1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ACCESS;
                        bus_rw_d    = req_store;
                        bus_len_d   = req_len;
                        bus_addr_d  = ea;
                        bus_write_d = req_store ? mask_len(req_wdata, req_len) : 32'h0;
                        unsigned_d  = req_funct3[2];
                        wait_d      = WAIT_INIT;
                    end
                end
            end
            ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    bus_rw_d     = 1'b0;
                    if (ZERO_IDLE_ADDR) begin
                        bus_addr_d  = 32'h0;
                        bus_write_d = 32'h0;
                    end
                    if (bus_exception) begin
                        resp_exc_d   = 1'b1;
                        resp_cause_d = 2'd2;
                        resp_rdata_d = 32'h0;
                    end else if (bus_rw_q) begin
                        resp_rdata_d = 32'h0;
                    end else begin
                        resp_rdata_d = extend_load(bus_read, bus_len_q, unsigned_q);
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_q       <= 4'd0;
            unsigned_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_exc_q   <= 1'b0;
            resp_cause_q <= 2'd0;
            bus_rw_q     <= 1'b0;
            bus_len_q    <= 2'd0;
            bus_addr_q   <= 32'h0;
            bus_write_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            unsigned_q   <= unsigned_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_exc_q   <= resp_exc_d;
            resp_cause_q <= resp_cause_d;
            bus_rw_q     <= bus_rw_d;
            bus_len_q    <= bus_len_d;
            bus_addr_q   <= bus_addr_d;
            bus_write_q  <= bus_write_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_exc   = resp_exc_q;
    assign resp_cause = resp_cause_q;
    assign bus_rw     = bus_rw_q;
    assign bus_len    = bus_len_q;
    assign bus_addr   = bus_addr_q;
    assign bus_write  = bus_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a zero-wait unit with idle zeroing and a
// three-wait unit that holds its bus values while idle.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        rv0 = 1'b0, rv3 = 1'b0, st = 1'b0, bexc = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] base = 32'h0, wd = 32'h0, rd = 32'h0;
    logic [11:0] off = 12'h0;

    logic        rr0, rsv0, rexc0, brw0, rr3, rsv3, rexc3, brw3;
    logic [31:0] rdat0, baddr0, bwr0, rdat3, baddr3, bwr3;
    logic [1:0]  rcause0, blen0, rcause3, blen3;

    load_store_unit #(.WAIT_CYCLES(0), .ZERO_IDLE_ADDR(1'b1)) dut0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rr0), .req_store(st),
        .req_funct3(f3), .req_base(base), .req_offset(off), .req_wdata(wd),
        .resp_valid(rsv0), .resp_rdata(rdat0), .resp_exc(rexc0), .resp_cause(rcause0),
        .bus_rw(brw0), .bus_len(blen0), .bus_addr(baddr0), .bus_write(bwr0),
        .bus_read(rd), .bus_exception(bexc));

    load_store_unit #(.WAIT_CYCLES(3), .ZERO_IDLE_ADDR(1'b0)) dut3 (
        .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rr3), .req_store(st),
        .req_funct3(f3), .req_base(base), .req_offset(off), .req_wdata(wd),
        .resp_valid(rsv3), .resp_rdata(rdat3), .resp_exc(rexc3), .resp_cause(rcause3),
        .bus_rw(brw3), .bus_len(blen3), .bus_addr(baddr3), .bus_write(bwr3),
        .bus_read(rd), .bus_exception(bexc));

    logic        sel = 1'b0;
    logic        m_rr, m_rsv, m_rexc, m_brw;
    logic [31:0] m_rdat, m_baddr, m_bwr;
    logic [1:0]  m_rcause, m_blen;
    assign m_rr     = sel ? rr3 : rr0;
    assign m_rsv    = sel ? rsv3 : rsv0;
    assign m_rexc   = sel ? rexc3 : rexc0;
    assign m_brw    = sel ? brw3 : brw0;
    assign m_rdat   = sel ? rdat3 : rdat0;
    assign m_baddr  = sel ? baddr3 : baddr0;
    assign m_bwr    = sel ? bwr3 : bwr0;
    assign m_rcause = sel ? rcause3 : rcause0;
    assign m_blen   = sel ? blen3 : blen0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int          lat, rw_cyc;
    logic [31:0] a_addr, a_write, r_data;
    logic [1:0]  a_len, r_cause;
    logic        r_exc, rdy_seen, addr_nz, got;

    // Issue one request and observe it until its response (bounded).
    task automatic run_req(input logic s, input logic store, input logic [2:0] fn,
                           input logic [31:0] b, input logic [11:0] o,
                           input logic [31:0] w, input logic hold);
        logic seen;
        sel = s;
        @(negedge clk);
        st = store; f3 = fn; base = b; off = o; wd = w;
        if (s) rv3 = 1'b1; else rv0 = 1'b1;
        lat = 0; rw_cyc = 0; got = 1'b0; rdy_seen = 1'b0; addr_nz = 1'b0; seen = 1'b0;
        a_addr = 32'h0; a_write = 32'h0; a_len = 2'd0;
        r_data = 32'h0; r_exc = 1'b0; r_cause = 2'd0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (!hold) begin rv0 = 1'b0; rv3 = 1'b0; end
            @(negedge clk);
            if (m_brw) rw_cyc++;
            if (m_baddr != 32'h0) addr_nz = 1'b1;
            if (m_rr) rdy_seen = 1'b1;
            if (!m_rr && !m_rsv && !seen) begin
                seen = 1'b1; a_addr = m_baddr; a_len = m_blen; a_write = m_bwr;
            end
            if (m_rsv) begin
                got = 1'b1; lat = i; r_data = m_rdat; r_exc = m_rexc; r_cause = m_rcause;
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_fault(input string tag, input logic [1:0] cause);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_exc"}, 32'(r_exc), 32'd1);
        check({tag, "_cause"}, 32'(r_cause), 32'(cause));
        check({tag, "_rw"}, 32'(rw_cyc), 32'd0);
        check({tag, "_rdata"}, r_data, 32'h0);
    endtask

    task automatic check_load(input string tag, input int exp_lat, input logic [31:0] addr,
                              input logic [1:0] len, input logic [31:0] data);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_addr"}, a_addr, addr);
        check({tag, "_len"}, 32'(a_len), 32'(len));
        check({tag, "_rw"}, 32'(rw_cyc), 32'd0);
        check({tag, "_rdata"}, r_data, data);
        check({tag, "_exc"}, 32'(r_exc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        check("rst_ready", 32'(m_rr), 32'd1);
        check("rst_rvalid", 32'(m_rsv), 32'd0);
        check("rst_rdata", m_rdat, 32'h0);
        check("rst_exc", 32'(m_rexc), 32'd0);
        check("rst_cause", 32'(m_rcause), 32'd0);
        check("rst_rw", 32'(m_brw), 32'd0);
        check("rst_len", 32'(m_blen), 32'd0);
        check("rst_addr", m_baddr, 32'h0);
        check("rst_write", m_bwr, 32'h0);
        check("rst_ready3", 32'(rr3), 32'd1);
        reset = 1'b0;

        rd = 32'hDEADBEEF;
        run_req(1'b0, 1'b0, 3'b010, 32'h100, 12'h004, 32'h0, 1'b0);
        check_load("lw", 2, 32'h104, 2'd2, 32'hDEADBEEF);
        check("lw_cause", 32'(r_cause), 32'd0);
        @(negedge clk);
        check("lw_rv_drop", 32'(m_rsv), 32'd0);
        check("lw_rdata_hold", m_rdat, 32'hDEADBEEF);
        check("lw_idle_addr", m_baddr, 32'h0);
        check("lw_idle_ready", 32'(m_rr), 32'd1);

        rd = 32'h00000080;
        run_req(1'b0, 1'b0, 3'b000, 32'h200, 12'h003, 32'h0, 1'b0);
        check_load("lb", 2, 32'h203, 2'd0, 32'hFFFFFF80);
        run_req(1'b0, 1'b0, 3'b100, 32'h200, 12'h003, 32'h0, 1'b0);
        check_load("lbu", 2, 32'h203, 2'd0, 32'h00000080);
        rd = 32'h00008001;
        run_req(1'b0, 1'b0, 3'b001, 32'h200, 12'h002, 32'h0, 1'b0);
        check_load("lh", 2, 32'h202, 2'd1, 32'hFFFF8001);
        run_req(1'b0, 1'b0, 3'b101, 32'h200, 12'h002, 32'h0, 1'b0);
        check_load("lhu", 2, 32'h202, 2'd1, 32'h00008001);

        run_req(1'b0, 1'b1, 3'b001, 32'h10, 12'hFFE, 32'h12345678, 1'b0);
        check("sh_addr", a_addr, 32'h0000000E);
        check("sh_len", 32'(a_len), 32'd1);
        check("sh_write", a_write, 32'h00005678);
        check("sh_rw_cycles", 32'(rw_cyc), 32'd1);
        check("sh_rdata", r_data, 32'h0);
        check("sh_exc", 32'(r_exc), 32'd0);
        run_req(1'b0, 1'b1, 3'b000, 32'h0, 12'h005, 32'hAABBCCDD, 1'b0);
        check("sb_addr", a_addr, 32'h00000005);
        check("sb_write", a_write, 32'h000000DD);
        check("sb_rw_cycles", 32'(rw_cyc), 32'd1);

        rd = 32'h11223344;
        run_req(1'b0, 1'b0, 3'b010, 32'hFFFFFFFF, 12'h005, 32'h0, 1'b0);
        check_load("wrap_up", 2, 32'h00000004, 2'd2, 32'h11223344);
        run_req(1'b0, 1'b0, 3'b010, 32'h0, 12'hFFC, 32'h0, 1'b0);
        check_load("wrap_down", 2, 32'hFFFFFFFC, 2'd2, 32'h11223344);

        run_req(1'b0, 1'b0, 3'b010, 32'h100, 12'h002, 32'h0, 1'b0);
        check_fault("lw_mis", 2'd1);
        check("lw_mis_addr_nz", 32'(addr_nz), 32'd0);
        @(negedge clk);
        check("fault_rv_drop", 32'(m_rsv), 32'd0);
        check("fault_exc_drop", 32'(m_rexc), 32'd0);
        check("fault_cause_drop", 32'(m_rcause), 32'd0);
        run_req(1'b0, 1'b0, 3'b011, 32'h101, 12'h000, 32'h0, 1'b0);
        check_fault("f3_011", 2'd3);
        run_req(1'b0, 1'b0, 3'b110, 32'h100, 12'h000, 32'h0, 1'b0);
        check_fault("f3_110", 2'd3);
        run_req(1'b0, 1'b1, 3'b100, 32'h100, 12'h000, 32'h0, 1'b0);
        check_fault("st_f3_100", 2'd3);
        run_req(1'b0, 1'b0, 3'b001, 32'h203, 12'h000, 32'h0, 1'b0);
        check_fault("lh_mis", 2'd1);
        run_req(1'b0, 1'b0, 3'b101, 32'h201, 12'h000, 32'h0, 1'b0);
        check_fault("lhu_mis", 2'd1);

        rd = 32'hCAFE1234;
        run_req(1'b1, 1'b0, 3'b010, 32'h40, 12'h000, 32'h0, 1'b0);
        check_load("w3_lw", 5, 32'h40, 2'd2, 32'hCAFE1234);
        @(negedge clk);
        check("w3_idle_addr_hold", m_baddr, 32'h40);
        check("w3_idle_rw", 32'(m_brw), 32'd0);

        bexc = 1'b1;
        run_req(1'b1, 1'b1, 3'b010, 32'h8, 12'h000, 32'hCAFEF00D, 1'b1);
        check("w3_sw_lat", 32'(lat), 32'd5);
        check("w3_sw_rw_cycles", 32'(rw_cyc), 32'd4);
        check("w3_sw_addr", a_addr, 32'h8);
        check("w3_sw_write", a_write, 32'hCAFEF00D);
        check("w3_sw_exc", 32'(r_exc), 32'd1);
        check("w3_sw_cause", 32'(r_cause), 32'd2);
        check("w3_sw_rdata", r_data, 32'h0);
        check("w3_held_not_ready", 32'(rdy_seen), 32'd0);
        @(negedge clk);
        check("w3_held_idle_ready", 32'(m_rr), 32'd1);
        check("w3_held_rv_drop", 32'(m_rsv), 32'd0);
        @(negedge clk);
        check("w3_held_accept", 32'(m_brw), 32'd1);
        rv3 = 1'b0;
        bexc = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt == 0; i++) begin
            @(negedge clk);
            if (m_rsv) cnt = 1;
        end
        check("w3_held_drain", 32'(cnt), 32'd1);

        sel = 1'b1;
        @(negedge clk);
        st = 1'b1; f3 = 3'b010; base = 32'h20; off = 12'h0; wd = 32'h55; rv3 = 1'b1;
        @(posedge clk);
        #1 rv3 = 1'b0;
        @(negedge clk);
        check("rst_acc_rw_pre", 32'(m_brw), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_acc_rw", 32'(m_brw), 32'd0);
        check("rst_acc_ready", 32'(m_rr), 32'd1);
        check("rst_acc_rv", 32'(m_rsv), 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_rsv) cnt++;
        end
        check("rst_acc_no_resp", 32'(cnt), 32'd0);
        rd = 32'h0BADF00D;
        run_req(1'b1, 1'b0, 3'b010, 32'h24, 12'h000, 32'h0, 1'b0);
        check_load("rst_after_lw", 5, 32'h24, 2'd2, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
